// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF/MEM stage requests, stall/done feedback and the
// single-port memory handshake. The arbiter uses 'master'; the pipeline/memory side uses 'slave'.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_rq;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              stall_if;
    logic              mem_rq;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_done;
    logic              stall_mem;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;
    logic              err_spur;

    modport master (
        input  if_rq, if_addr, mem_rq, mem_we, mem_addr, mem_wdata, m_rdata, m_ack,
        output if_rdata, if_done, stall_if, mem_rdata_o, mem_done, stall_mem,
               m_req, m_we, m_addr, m_wdata, err_spur
    );

    modport slave (
        output if_rq, if_addr, mem_rq, mem_we, mem_addr, mem_wdata, m_rdata, m_ack,
        input  if_rdata, if_done, stall_if, mem_rdata_o, mem_done, stall_mem,
               m_req, m_we, m_addr, m_wdata, err_spur
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between IF fetches and MEM loads/stores (MEM first).
// Define MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_MAX MEM grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    state_t state, state_nxt;
    logic   if_ok, mem_ok, force_if, grant_if, grant_mem;

    if (ADDR_W < 1 || DATA_W < 1 || STARVE_MAX < 1) begin : g_param_check
        $error("mem_port_arbiter: bad parameters");
    end

    // A requester whose done is pulsing is still presenting the finished request.
    assign if_ok  = bus.if_rq  & ~bus.if_done;
    assign mem_ok = bus.mem_rq & ~bus.mem_done;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    logic [CNT_W-1:0] starve_cnt;

    assign force_if = if_ok & (starve_cnt >= CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst || !bus.if_rq || grant_if)
            starve_cnt <= '0;
        else if (grant_mem && if_ok && starve_cnt < CNT_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign force_if = 1'b0;
`endif

    // A held mem_rq keeps priority even through its own done cycle, so IF can only
    // slip in when MEM has dropped its request or the starvation guard fires.
    assign grant_mem = (state == IDLE) & mem_ok & ~force_if;
    assign grant_if  = (state == IDLE) & if_ok & (~bus.mem_rq | force_if);

    assign bus.stall_if  = bus.if_rq  & ~bus.if_done;
    assign bus.stall_mem = bus.mem_rq & ~bus.mem_done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_mem)     state_nxt = BUSY_MEM;
                else if (grant_if) state_nxt = BUSY_IF;
            end
            BUSY_IF, BUSY_MEM: if (bus.m_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_req       <= 1'b0;
            bus.m_we        <= 1'b0;
            bus.m_addr      <= '0;
            bus.m_wdata     <= '0;
            bus.if_rdata    <= '0;
            bus.mem_rdata_o <= '0;
            bus.if_done     <= 1'b0;
            bus.mem_done    <= 1'b0;
            bus.err_spur    <= 1'b0;
        end else begin
            bus.if_done  <= 1'b0;
            bus.mem_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.m_ack) bus.err_spur <= 1'b1;
                    if (grant_mem) begin
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= bus.mem_we;
                        bus.m_addr  <= bus.mem_addr;
                        bus.m_wdata <= bus.mem_wdata;
                    end else if (grant_if) begin
                        bus.m_req  <= 1'b1;
                        bus.m_we   <= 1'b0;
                        bus.m_addr <= bus.if_addr;
                    end
                end
                BUSY_IF: if (bus.m_ack) begin
                    bus.m_req    <= 1'b0;
                    bus.if_done  <= 1'b1;
                    bus.if_rdata <= bus.m_rdata;
                end
                BUSY_MEM: if (bus.m_ack) begin
                    bus.m_req    <= 1'b0;
                    bus.mem_done <= 1'b1;
                    if (!bus.m_we) bus.mem_rdata_o <= bus.m_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
